ula_sync_bridge: RTL and testbench

//  Clocked front/back end for the dual-rail NCL ULA: takes single-rail operands via valid/ready,

---
 rtl/ula_sync_bridge_pkg.sv | 53 +++++
 rtl/ula_sync_bridge_if.sv | 44 ++++
 rtl/ula_sync_bridge_ncl_completion_sync.sv | 39 +++
 rtl/ula_sync_bridge.sv | 147 ++++++++++++++
 tb/tb_ula_sync_bridge.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_sync_bridge_pkg.sv
// Shared types and dual-rail NCL helpers for the ULA sync bridge.
// Pair encoding {rail1, rail0}: 00 NULL, 01 logic 0, 10 logic 1, 11 illegal.
package ula_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_AND = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_DATA_WAIT = 2'b01,
    ST_NULL_WAIT = 2'b10
  } state_t;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;

  // Completion helpers take a zero-padded vector plus the number of live pairs.
  localparam int unsigned DR_MAX_PAIRS = 32;

  function automatic logic [1:0] dr_encode(input logic b);
    return b ? DR_1 : DR_0;
  endfunction

  function automatic logic dr_decode(input logic [1:0] p);
    return p[1];
  endfunction

  function automatic logic dr_all_data(input logic [2*DR_MAX_PAIRS-1:0] v,
                                       input int unsigned n);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DR_MAX_PAIRS; i++) begin
      if (i < n && !(v[2*i+1] ^ v[2*i])) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic dr_all_null(input logic [2*DR_MAX_PAIRS-1:0] v,
                                       input int unsigned n);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DR_MAX_PAIRS; i++) begin
      if (i < n && (v[2*i+1] | v[2*i])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/ula_sync_bridge_if.sv
// Request/response handshake plus dual-rail ULA bus of the sync bridge.
// slave = bridge side; master = sync core / ULA side.
interface ula_sync_bridge_if #(
  parameter int unsigned DW = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic [1:0]      in_op;
  logic            in_cin;

  logic [2*DW-1:0] ula_a;
  logic [2*DW-1:0] ula_b;
  logic [1:0]      ula_sel0;
  logic [1:0]      ula_sel1;
  logic [1:0]      ula_cin;
  logic [2*DW-1:0] ula_out;
  logic [1:0]      ula_ovf;
  logic [1:0]      ula_neg;
  logic [1:0]      ula_zero;

  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_res;
  logic            out_ovf;
  logic            out_neg;
  logic            out_zero;
  logic            out_err;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
           ula_out, ula_ovf, ula_neg, ula_zero,
    output in_ready, ula_a, ula_b, ula_sel0, ula_sel1, ula_cin,
           out_valid, out_res, out_ovf, out_neg, out_zero, out_err
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_cin, out_ready,
           ula_out, ula_ovf, ula_neg, ula_zero,
    input  in_ready, ula_a, ula_b, ula_sel0, ula_sel1, ula_cin,
           out_valid, out_res, out_ovf, out_neg, out_zero, out_err
  );
endinterface

// File: rtl/ula_sync_bridge_ncl_completion_sync.sv
// All-DATA / all-NULL detection over the ULA result rails, synchronised into clk.
module ncl_completion_sync
  import ula_pkg::*;
#(
  parameter int unsigned NP          = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2*NP-1:0] rails,
  output logic            data_done_s,
  output logic            null_done_s
);
  logic [2*DR_MAX_PAIRS-1:0] flat;
  logic                      data_done;
  logic                      null_done;
  logic [SYNC_STAGES-1:0]    dd_q;
  logic [SYNC_STAGES-1:0]    nd_q;

  always_comb begin
    flat            = '0;
    flat[2*NP-1:0]  = rails;
    data_done       = dr_all_data(flat, NP);
    null_done       = dr_all_null(flat, NP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dd_q <= '0;
      nd_q <= '0;
    end else begin
      dd_q <= {dd_q[SYNC_STAGES-2:0], data_done};
      nd_q <= {nd_q[SYNC_STAGES-2:0], null_done};
    end
  end

  assign data_done_s = dd_q[SYNC_STAGES-1];
  assign null_done_s = nd_q[SYNC_STAGES-1];
endmodule

// File: rtl/ula_sync_bridge.sv
// Clocked valid/ready front end for the dual-rail NCL ULA (DATA/NULL wavefront sequencing).
// Optional ULA_TIMEOUT_EN: per-wavefront timeout reporting via out_err.
module ula_sync_bridge
  import ula_pkg::*;
#(
  parameter int unsigned DW             = 5,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              rst,
  ula_sync_bridge_if.slave bus
);
  localparam int unsigned NP = DW + 3;

  state_t state;
  logic   dd_s;
  logic   nd_s;
  logic   accept;

  ncl_completion_sync #(
    .NP          (NP),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .rails       ({bus.ula_zero, bus.ula_neg, bus.ula_ovf, bus.ula_out}),
    .data_done_s (dd_s),
    .null_done_s (nd_s)
  );

  // NULL_WAIT with nd_s is the same point as IDLE, so a request is taken there directly.
  assign bus.in_ready = (state != ST_DATA_WAIT) && nd_s &&
                        (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef ULA_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  logic [CNT_W-1:0] cnt;
  logic             expired;
  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign bus.out_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      bus.ula_a    <= '0;
      bus.ula_b    <= '0;
      bus.ula_sel0 <= '0;
      bus.ula_sel1 <= '0;
      bus.ula_cin  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_res  <= '0;
      bus.out_ovf  <= 1'b0;
      bus.out_neg  <= 1'b0;
      bus.out_zero <= 1'b0;
`ifdef ULA_TIMEOUT_EN
      bus.out_err  <= 1'b0;
      cnt          <= '0;
`endif
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
`ifdef ULA_TIMEOUT_EN
        bus.out_err   <= 1'b0;
`endif
      end

      case (state)
        ST_IDLE, ST_NULL_WAIT: begin
          if (accept) begin
            for (int unsigned i = 0; i < DW; i++) begin
              bus.ula_a[2*i +: 2] <= dr_encode(bus.in_a[i]);
              bus.ula_b[2*i +: 2] <= dr_encode(bus.in_b[i]);
            end
            bus.ula_sel0 <= dr_encode(bus.in_op[0]);
            bus.ula_sel1 <= dr_encode(bus.in_op[1]);
            bus.ula_cin  <= dr_encode(bus.in_cin);
            state        <= ST_DATA_WAIT;
`ifdef ULA_TIMEOUT_EN
            cnt          <= '0;
`endif
          end else if (state == ST_NULL_WAIT) begin
            if (nd_s) begin
              state <= ST_IDLE;
            end
`ifdef ULA_TIMEOUT_EN
            else if (expired) begin
              bus.out_res   <= '0;
              bus.out_ovf   <= 1'b0;
              bus.out_neg   <= 1'b0;
              bus.out_zero  <= 1'b0;
              bus.out_err   <= 1'b1;
              bus.out_valid <= 1'b1;
              cnt           <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
`endif
          end
        end

        ST_DATA_WAIT: begin
          if (dd_s) begin
            for (int unsigned i = 0; i < DW; i++) begin
              bus.out_res[i] <= dr_decode(bus.ula_out[2*i +: 2]);
            end
            bus.out_ovf   <= dr_decode(bus.ula_ovf);
            bus.out_neg   <= dr_decode(bus.ula_neg);
            bus.out_zero  <= dr_decode(bus.ula_zero);
            bus.out_valid <= 1'b1;
            bus.ula_a     <= '0;
            bus.ula_b     <= '0;
            bus.ula_sel0  <= '0;
            bus.ula_sel1  <= '0;
            bus.ula_cin   <= '0;
            state         <= ST_NULL_WAIT;
`ifdef ULA_TIMEOUT_EN
            bus.out_err   <= 1'b0;
            cnt           <= '0;
          end else if (expired) begin
            bus.out_res   <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_neg   <= 1'b0;
            bus.out_zero  <= 1'b0;
            bus.out_err   <= 1'b1;
            bus.out_valid <= 1'b1;
            bus.ula_a     <= '0;
            bus.ula_b     <= '0;
            bus.ula_sel0  <= '0;
            bus.ula_sel1  <= '0;
            bus.ula_cin   <= '0;
            state         <= ST_NULL_WAIT;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_sync_bridge.sv
// Directed bench for ula_sync_bridge with a behavioural dual-rail ULA and a result scoreboard.
// Honours ULA_TIMEOUT_EN in the same way as the design.
module tb_ula_sync_bridge;
  import ula_pkg::*;

  localparam int unsigned DW = 5;
  localparam int unsigned SS = 2;
  localparam int unsigned TC = 64;

  logic clk = 1'b0;
  logic rst;
  logic hold = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [8:0] sb[$];
  logic [8:0] mon_got;

  always #5 clk = ~clk;

  ula_sync_bridge_if #(.DW(DW)) bus ();

  ula_sync_bridge #(
    .DW             (DW),
    .SYNC_STAGES    (SS),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {err, zero, neg, ovf, res}
  function automatic logic [8:0] ref_op(input logic [4:0] a, input logic [4:0] b,
                                        input logic [1:0] op, input logic cin);
    logic [4:0] r;
    logic       v;
    r = '0;
    v = 1'b0;
    case (op)
      OP_ADD: begin r = a + b + {4'b0, cin}; v = (a[4] == b[4]) && (r[4] != a[4]); end
      OP_SUB: begin r = a - b - {4'b0, cin}; v = (a[4] != b[4]) && (r[4] != a[4]); end
      OP_XOR: r = a ^ b;
      default: r = a & b;
    endcase
    return {1'b0, r == 5'd0, r[4], v, r};
  endfunction

  function automatic logic [9:0] enc5(input logic [4:0] x);
    logic [9:0] e;
    e = '0;
    for (int i = 0; i < 5; i++) e[2*i +: 2] = x[i] ? 2'b10 : 2'b01;
    return e;
  endfunction

  // Behavioural ULA: combinational, answers only a complete DATA wavefront.
  logic       m_data;
  logic [4:0] m_a, m_b;
  logic [8:0] m_y;
  always_comb begin
    m_data = 1'b1;
    m_a = '0;
    m_b = '0;
    m_y = '0;
    bus.ula_out  = '0;
    bus.ula_ovf  = '0;
    bus.ula_neg  = '0;
    bus.ula_zero = '0;
    for (int i = 0; i < 5; i++) begin
      if (bus.ula_a[2*i+1] == bus.ula_a[2*i]) m_data = 1'b0;
      if (bus.ula_b[2*i+1] == bus.ula_b[2*i]) m_data = 1'b0;
      m_a[i] = bus.ula_a[2*i+1];
      m_b[i] = bus.ula_b[2*i+1];
    end
    if (bus.ula_sel0[1] == bus.ula_sel0[0]) m_data = 1'b0;
    if (bus.ula_sel1[1] == bus.ula_sel1[0]) m_data = 1'b0;
    if (bus.ula_cin[1]  == bus.ula_cin[0])  m_data = 1'b0;
    if (m_data && !hold) begin
      m_y = ref_op(m_a, m_b, {bus.ula_sel1[1], bus.ula_sel0[1]}, bus.ula_cin[1]);
      bus.ula_out  = enc5(m_y[4:0]);
      bus.ula_ovf  = m_y[5] ? 2'b10 : 2'b01;
      bus.ula_neg  = m_y[6] ? 2'b10 : 2'b01;
      bus.ula_zero = m_y[7] ? 2'b10 : 2'b01;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop on each completed output handshake.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      mon_got = {bus.out_err, bus.out_zero, bus.out_neg, bus.out_ovf, bus.out_res};
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_result: observed=%0h expected=none", mon_got);
      end
      if (sb.size() != 0) chk("result", {23'b0, mon_got}, {23'b0, sb.pop_front()});
    end
  end

  task automatic issue(input logic [4:0] a, input logic [4:0] b,
                       input logic [1:0] op, input logic cin);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_cin = cin;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("accept", {31'b0, ok}, 32'd1);
    if (ok) sb.push_back(ref_op(a, b, op, cin));
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [4:0] a, input logic [4:0] b,
                        input logic [1:0] op, input logic cin);
    int n;
    issue(a, b, op, cin);
    chk("ula_a_data", {22'b0, bus.ula_a}, {22'b0, enc5(a)});
    chk("ula_b_data", {22'b0, bus.ula_b}, {22'b0, enc5(b)});
    wait_valid(50, n);
    chk("latency", n, SS + 1);
    chk("ula_null_after_capture",
        {16'b0, bus.ula_a, bus.ula_b, bus.ula_sel0, bus.ula_sel1, bus.ula_cin}, 32'd0);
  endtask

  initial begin
    int n;
    logic [4:0] held;
    bit ok;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.in_cin = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ula", {12'b0, bus.ula_a, bus.ula_b}, 32'd0);
    chk("reset_out", {23'b0, bus.out_valid, bus.out_res, bus.out_ovf, bus.out_neg, bus.out_zero},
        32'd0);
    chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", {31'b0, bus.in_ready}, 32'd0);

    issue(5'd3, 5'd4, OP_ADD, 1'b0);
    chk("add_ula_a_literal", {22'b0, bus.ula_a}, {22'b0, 10'b01_01_01_10_10});
    wait_valid(50, n);
    chk("add_latency", n, SS + 1);

    run_op(5'd2, 5'd5, OP_SUB, 1'b0);
    run_op(5'd15, 5'd1, OP_ADD, 1'b0);
    run_op(5'd9, 5'd9, OP_XOR, 1'b0);
    run_op(5'b10110, 5'b01111, OP_AND, 1'b0);
    run_op(5'b10000, 5'd1, OP_SUB, 1'b0);
    run_op(5'd7, 5'd8, OP_ADD, 1'b1);

    // Backpressure: result held, no new request accepted.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(5'd1, 5'd2, OP_ADD, 1'b0);
    wait_valid(50, n);
    chk("bp_latency", n, SS + 1);
    held = bus.out_res;
    bus.in_a = 5'd4; bus.in_b = 5'd4; bus.in_op = OP_ADD; bus.in_cin = 1'b0;
    bus.in_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.out_res !== held || bus.out_valid !== 1'b1) ok = 1'b0;
    end
    chk("bp_stall_stable", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    run_op(5'd4, 5'd4, OP_ADD, 1'b0);

    // Completion withheld by the ULA.
    @(posedge clk); #1;
    hold = 1'b1;
    issue(5'd6, 5'd1, OP_ADD, 1'b0);
`ifdef ULA_TIMEOUT_EN
    void'(sb.pop_back());
    sb.push_back(9'h100);
    wait_valid(100, n);
    chk("timeout_cycles", n, TC + 1);
    chk("timeout_err", {31'b0, bus.out_err}, 32'd1);
    @(posedge clk); #1;
    hold = 1'b0;
`else
    wait_valid(100, n);
    chk("no_valid_while_withheld", n, -1);
    hold = 1'b0;
    wait_valid(20, n);
    chk("valid_after_release", {31'b0, n >= 0}, 32'd1);
`endif
    run_op(5'd6, 5'd2, OP_SUB, 1'b0);

    // Reset pulse during DATA_WAIT.
    issue(5'd2, 5'd2, OP_ADD, 1'b0);
    void'(sb.pop_back());
    rst = 1'b1;
    #1;
    chk("rst_ula_null",
        {16'b0, bus.ula_a, bus.ula_b, bus.ula_sel0, bus.ula_sel1, bus.ula_cin}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_waits_nd", {31'b0, bus.in_ready}, 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1'b1;
    end
    chk("rst_ready_returns", {31'b0, ok}, 32'd1);
    run_op(5'b11111, 5'b11111, OP_ADD, 1'b0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
